// File: rtl/multitap_delay.sv
// -----------------------------------------------------------------------------
// multitap_delay
//
// Circular-buffer delay line with NTAPS independent read taps. Each en cycle
// writes one sample at the write pointer; every tap reads the sample written
// off_k en-cycles earlier. Tap reads and the valid flags are registered, and
// the sum of all valid taps (mix) is registered one clock later.
//
// Optional build macro: MULTITAP_DELAY_ECHO_EN adds the 'echo' input. When it
// is set and tap 0 is valid, half of tap 0 is fed back into the written
// sample, with saturation.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset
//   en      sample strobe (write one sample, advance all taps)
//   flush   clear fill count and tap outputs; pointer and memory untouched
//   off     per-tap delay, tap k at [k*A_WIDTH +: A_WIDTH]
//   signal  input sample
//   echo    feedback enable (MULTITAP_DELAY_ECHO_EN builds only)
//   dout    per-tap delayed sample, tap k at [k*D_WIDTH +: D_WIDTH]
//   dvalid  per-tap valid flag
//   mix     sum of valid tap outputs
// -----------------------------------------------------------------------------
module multitap_delay #(
    parameter int unsigned A_WIDTH = 8,
    parameter int unsigned D_WIDTH = 8,
    parameter int unsigned NTAPS   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [NTAPS*A_WIDTH-1:0]   off,
    input  logic [D_WIDTH-1:0]         signal,
`ifdef MULTITAP_DELAY_ECHO_EN
    input  logic                       echo,
`endif
    output logic [NTAPS*D_WIDTH-1:0]   dout,
    output logic [NTAPS-1:0]           dvalid,
    output logic [D_WIDTH+2:0]         mix
);

    localparam int unsigned DEPTH = 2 ** A_WIDTH;
    localparam int unsigned MIX_W = D_WIDTH + 3;
    localparam logic [A_WIDTH-1:0] FILL_MAX = {A_WIDTH{1'b1}};

    logic [D_WIDTH-1:0] mem [DEPTH];

    logic [A_WIDTH-1:0] wr_ptr_q;
    logic [A_WIDTH-1:0] fill_q;
    logic [D_WIDTH-1:0] dout_q [NTAPS];
    logic [NTAPS-1:0]   dvalid_q;
    logic [MIX_W-1:0]   mix_q;

    logic [D_WIDTH-1:0] wr_data;
    logic [A_WIDTH-1:0] tap_off  [NTAPS];
    logic [D_WIDTH-1:0] tap_data [NTAPS];
    logic [NTAPS-1:0]   tap_hit;
    logic [MIX_W-1:0]   mix_d;

    logic do_write;
    assign do_write = en && !flush;

    // Value written this cycle
`ifdef MULTITAP_DELAY_ECHO_EN
    logic [D_WIDTH:0] echo_sum;
    always_comb begin
        // dout_q[0] is the pre-update tap output, so feedback sees the old value
        echo_sum = {1'b0, signal} + {2'b00, dout_q[0][D_WIDTH-1:1]};
        wr_data  = signal;
        if (echo && dvalid_q[0]) begin
            wr_data = echo_sum[D_WIDTH] ? {D_WIDTH{1'b1}} : echo_sum[D_WIDTH-1:0];
        end
    end
`else
    always_comb begin
        wr_data = signal;
    end
`endif

    // Tap address and validity; off=0 forwards the sample being written
    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            tap_off[k]  = off[k*A_WIDTH +: A_WIDTH];
            tap_hit[k]  = (tap_off[k] <= fill_q);
            tap_data[k] = (tap_off[k] == '0) ? wr_data : mem[wr_ptr_q - tap_off[k]];
        end
    end

    // Sum of valid taps; registered into mix one clock after dout settles
    always_comb begin
        mix_d = '0;
        for (int k = 0; k < NTAPS; k++) begin
            if (dvalid_q[k]) begin
                mix_d = mix_d + MIX_W'(dout_q[k]);
            end
        end
    end

    // Sample memory: no reset, stale words are hidden by dvalid gating
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            fill_q   <= '0;
            dvalid_q <= '0;
            mix_q    <= '0;
            for (int k = 0; k < NTAPS; k++) begin
                dout_q[k] <= '0;
            end
        end else begin
            mix_q <= mix_d;
            if (flush) begin
                fill_q   <= '0;
                dvalid_q <= '0;
                for (int k = 0; k < NTAPS; k++) begin
                    dout_q[k] <= '0;
                end
            end else if (en) begin
                wr_ptr_q <= wr_ptr_q + A_WIDTH'(1);
                if (fill_q != FILL_MAX) begin
                    fill_q <= fill_q + A_WIDTH'(1);
                end
                dvalid_q <= tap_hit;
                for (int k = 0; k < NTAPS; k++) begin
                    dout_q[k] <= tap_hit[k] ? tap_data[k] : '0;
                end
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NTAPS; k++) begin
            dout[k*D_WIDTH +: D_WIDTH] = dout_q[k];
        end
    end

    assign dvalid = dvalid_q;
    assign mix    = mix_q;

endmodule

// File: tb/tb_multitap_delay.sv
module tb_multitap_delay;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int NT    = 4;
    localparam int DEPTH = 16;
    localparam int SMAX  = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic             echo = 1'b0;
    logic [NT*AW-1:0] off = '0;
    logic [DW-1:0]    signal = '0;
    logic [NT*DW-1:0] dout;
    logic [NT-1:0]    dvalid;
    logic [DW+2:0]    mix;

    multitap_delay #(
        .A_WIDTH (AW),
        .D_WIDTH (DW),
        .NTAPS   (NT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .flush  (flush),
        .off    (off),
        .signal (signal),
`ifdef MULTITAP_DELAY_ECHO_EN
        .echo   (echo),
`endif
        .dout   (dout),
        .dvalid (dvalid),
        .mix    (mix)
    );

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    typedef struct packed {
        logic [NT*DW-1:0] d;
        logic [NT-1:0]    v;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp = '0;

    // Reference model: list of samples written since the last reset/flush
    int m_hist[$];
    int m_dout[NT];
    bit m_valid[NT];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic int sum_of(exp_t e);
        int s = 0;
        for (int k = 0; k < NT; k++) if (e.v[k]) s += int'(e.d[k*DW +: DW]);
        return s;
    endfunction

    function automatic logic [NT*AW-1:0] mk_off(int a, int b, int c, int d);
        logic [NT*AW-1:0] r;
        r[0*AW +: AW] = AW'(a);
        r[1*AW +: AW] = AW'(b);
        r[2*AW +: AW] = AW'(c);
        r[3*AW +: AW] = AW'(d);
        return r;
    endfunction

    function automatic void model_step();
        exp_t e;
        int n, fillv, w, o;
        if (rst || flush) begin
            m_hist.delete();
            for (int k = 0; k < NT; k++) begin
                m_dout[k]  = 0;
                m_valid[k] = 1'b0;
            end
        end else if (en) begin
            n     = m_hist.size();
            fillv = (n > DEPTH - 1) ? DEPTH - 1 : n;
            w     = int'(signal);
`ifdef MULTITAP_DELAY_ECHO_EN
            if (echo && m_valid[0]) begin
                w = int'(signal) + m_dout[0] / 2;
                if (w > SMAX) w = SMAX;
            end
`endif
            m_hist.push_back(w);
            for (int k = 0; k < NT; k++) begin
                o          = int'(off[k*AW +: AW]);
                m_valid[k] = (o <= fillv);
                m_dout[k]  = m_valid[k] ? m_hist[n - o] : 0;
            end
        end else begin
            return;
        end
        for (int k = 0; k < NT; k++) begin
            e.d[k*DW +: DW] = DW'(m_dout[k]);
            e.v[k]          = m_valid[k];
        end
        exp_q.push_back(e);
    endfunction

    task automatic step(input bit r, input bit f, input bit e,
                        input logic [NT*AW-1:0] o, input int s, input bit ec);
        rst    = r;
        flush  = f;
        en     = e;
        off    = o;
        signal = DW'(s);
        echo   = ec;
        model_step();
        @(posedge clk);
        #1;
    endtask

    function automatic int tap(int k);
        return int'(dout[k*DW +: DW]);
    endfunction

    // Monitor: an output update is due after every edge that saw rst/flush/en
    bit ev_d  = 1'b0;
    bit rst_d = 1'b0;
    always @(posedge clk) begin
        ev_d  <= (rst === 1'b1) || (flush === 1'b1) || (en === 1'b1);
        rst_d <= (rst === 1'b1);
    end

    always @(negedge clk) begin : monitor
        int ps;
        ps = sum_of(cur_exp);
        if (chk_on) check("mix", 32'(mix), rst_d ? 0 : ps);
        if (ev_d) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_underflow: got empty queue expected entry at %0t", $time);
            end else begin
                cur_exp = exp_q.pop_front();
            end
        end
        if (chk_on) begin
            check("dout", dout, 32'(cur_exp.d));
            check("dvalid", 32'(dvalid), 32'(cur_exp.v));
        end
    end

    initial begin
        logic [NT*AW-1:0] o;
        int post[10];

        step(1, 0, 0, '0, 0, 0);
        step(1, 0, 0, '0, 0, 0);
        chk_on = 1'b1;
        check("reset_dvalid", 32'(dvalid), 0);
        check("reset_dout", dout, 0);

        // Basic: tap0 bypass, tap1 delay 3
        o = mk_off(0, 3, 1, 2);
        for (int i = 1; i <= 10; i++) begin
            step(0, 0, 1, o, i, 0);
            check("tap0_follow", tap(0), i);
            if (i == 3) check("tap1_not_valid", 32'(dvalid[1]), 0);
            if (i == 4) begin
                check("tap1_first_valid", 32'(dvalid[1]), 1);
                check("tap1_first_data", tap(1), 1);
            end
            if (i == 10) check("tap1_tenth", tap(1), 7);
        end

        // en gating at 1/3 duty
        o = mk_off(2, 5, 0, 9);
        for (int i = 0; i < 36; i++) step(0, 0, (i % 3) == 0, o, $urandom_range(0, 255), 0);

        // Flush with concurrent en: flush wins, then no stale data
        o = mk_off(5, 1, 0, 3);
        for (int i = 0; i < 20; i++) step(0, 0, 1, o, $urandom_range(0, 255), 0);
        step(0, 1, 1, o, 99, 0);
        check("flush_dvalid", 32'(dvalid), 0);
        for (int j = 0; j < 10; j++) begin
            post[j] = int'($urandom_range(0, 255));
            step(0, 0, 1, o, post[j], 0);
            if (j < 5) begin
                check("flush_tap0_invalid", 32'(dvalid[0]), 0);
                check("flush_tap0_zero", tap(0), 0);
            end else begin
                check("flush_tap0_valid", 32'(dvalid[0]), 1);
                check("flush_tap0_data", tap(0), post[j - 5]);
            end
        end

        // Pointer wrap with maximum delay
        step(1, 0, 0, '0, 0, 0);
        o = mk_off(15, 1, 7, 0);
        for (int n = 0; n < 40; n++) begin
            step(0, 0, 1, o, n, 0);
            if (n == 14) check("wrap_not_valid", 32'(dvalid[0]), 0);
            if (n >= 15) check("wrap_tap0", tap(0), n - 15);
        end

        // Full-scale mix
        o = mk_off(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, o, 255, 0);
        step(0, 0, 0, o, 0, 0);
        check("mix_full", 32'(mix), 1020);

`ifdef MULTITAP_DELAY_ECHO_EN
        // Echo impulse decay and saturation
        step(1, 0, 0, '0, 0, 0);
        o = mk_off(2, 0, 1, 3);
        step(0, 0, 1, o, 200, 1);
        for (int i = 0; i < 20; i++) step(0, 0, 1, o, 0, 1);
        o = mk_off(0, 1, 2, 3);
        for (int i = 0; i < 8; i++) step(0, 0, 1, o, 250, 1);
`endif

        // Randomised traffic
        o = mk_off(3, 8, 0, 15);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 7) == 0) o = NT*AW'($urandom);
            step($urandom_range(0, 199) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 7, o, $urandom_range(0, 255), $urandom_range(0, 1) == 1);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 0, o, 0, 0);
        check("scoreboard_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
